// File: rtl/sap_datapath.sv
// SAP-style CPU datapath: bus, registers, 16x8 RAM, ALU, flags and T-state counter.
// Optional macro SAP_BUS_CHECK_EN: flag and suppress cycles that drive more than one bus source.
module sap_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int STEPS  = 5
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [15:0]       ctrl,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [8:0]        instin,
  output logic [DATA_W-1:0] out_val,
  output logic              halted,
  output logic              bus_err
);

  localparam int STEP_W = 3;

  logic hlt, marwa, ramwa, ramoa, inregoa, inregwa, awa, aoa;
  logic sumout, sub, bwa, outregwa, pcinc, pcoe, pcjmp, flagsin;

  assign {hlt, marwa, ramwa, ramoa, inregoa, inregwa, awa, aoa,
          sumout, sub, bwa, outregwa, pcinc, pcoe, pcjmp, flagsin} = ctrl;

  logic [ADDR_W-1:0] pc, mar;
  logic [DATA_W-1:0] ir, a, b, out_r, bus, alu;
  logic [DATA_W:0]   s9;
  logic [STEP_W-1:0] step;
  logic              cf, zf;
  logic              active, conflict, do_write;

  logic [DATA_W-1:0] ram [2**ADDR_W];

  // Subtraction is A + ~B + 1, so carry-out set means no borrow.
  assign s9  = {1'b0, a} + {1'b0, b ^ {DATA_W{sub}}} + {{DATA_W{1'b0}}, sub};
  assign alu = s9[DATA_W-1:0];

  always_comb begin
    bus = '0;
    if (ramoa)        bus = ram[mar];
    else if (inregoa) bus = DATA_W'(ir[3:0]);
    else if (aoa)     bus = a;
    else if (sumout)  bus = alu;
    else if (pcoe)    bus = DATA_W'(pc);
  end

`ifdef SAP_BUS_CHECK_EN
  assign conflict = ($countones({ramoa, inregoa, aoa, sumout, pcoe}) > 1);
`else
  assign conflict = 1'b0;
`endif

  assign active   = run & ~halted;
  assign do_write = active & ~hlt & ~conflict;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pc     <= '0;
      mar    <= '0;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      out_r  <= '0;
      step   <= '0;
      cf     <= 1'b0;
      zf     <= 1'b0;
      halted <= 1'b0;
    end else if (!run) begin
      step <= '0;
    end else if (!halted) begin
      step <= (step == STEP_W'(STEPS - 1)) ? '0 : step + STEP_W'(1);
      if (hlt) begin
        halted <= 1'b1;
      end else if (!conflict) begin
        if (marwa)    mar   <= bus[ADDR_W-1:0];
        if (inregwa)  ir    <= bus;
        if (awa)      a     <= bus;
        if (bwa)      b     <= bus;
        if (outregwa) out_r <= bus;
        if (flagsin) begin
          cf <= s9[DATA_W];
          zf <= (alu == '0);
        end
        if (pcjmp)      pc <= bus[ADDR_W-1:0];
        else if (pcinc) pc <= pc + ADDR_W'(1);
      end
    end
  end

  // RAM is deliberately outside the reset domain so a loaded program survives clr_n.
  always_ff @(posedge clk) begin
    if (do_write && ramwa)    ram[mar]       <= bus;
    else if (!run && prog_we) ram[prog_addr] <= prog_data;
  end

`ifdef SAP_BUS_CHECK_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                        bus_err <= 1'b0;
    else if (active && !hlt && conflict) bus_err <= 1'b1;
  end
`else
  assign bus_err = 1'b0;
`endif

  assign instin  = {ir[7:4], step, cf, zf};
  assign out_val = out_r;

endmodule

// File: tb/tb_sap_datapath.sv
// Self-checking bench for sap_datapath: directed scenarios plus a randomized run
// compared against an arithmetic reference model of the datapath.
module tb_sap_datapath;

  localparam logic [15:0] C_HLT   = 16'h8000, C_MARWA = 16'h4000, C_RAMWA = 16'h2000,
                          C_RAMOA = 16'h1000, C_INOA  = 16'h0800, C_INWA  = 16'h0400,
                          C_AWA   = 16'h0200, C_AOA   = 16'h0100, C_SUM   = 16'h0080,
                          C_SUB   = 16'h0040, C_BWA   = 16'h0020, C_OUTWA = 16'h0010,
                          C_PCINC = 16'h0008, C_PCOE  = 16'h0004, C_PCJMP = 16'h0002,
                          C_FLAGS = 16'h0001;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [15:0] ctrl;
  logic       run, prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [8:0] instin;
  logic [7:0] out_val;
  logic       halted, bus_err;

  int tests = 0;
  int fails = 0;

  sap_datapath dut (
    .clk(clk), .clr_n(clr_n), .ctrl(ctrl), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .instin(instin),
    .out_val(out_val), .halted(halted), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, summary %0d run %0d failed", tests, fails);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic act(input logic [15:0] c);
    run  = 1'b1;
    ctrl = c;
    tick();
    ctrl = '0;
  endtask

  task automatic load_ram(input logic [3:0] ad, input logic [7:0] d);
    run = 1'b0; ctrl = '0;
    prog_we = 1'b1; prog_addr = ad; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic do_reset;
    ctrl = '0; run = 1'b0; prog_we = 1'b0;
    #2 clr_n = 1'b0;
    #2 clr_n = 1'b1;
  endtask

  // Minimal SAP-1 microcode: LDA=1, ADD=2, OUT=E, HLT=F.
  function automatic logic [15:0] ucode(input logic [8:0] ii);
    logic [3:0] op;
    logic [2:0] st;
    op = ii[8:5];
    st = ii[4:2];
    ucode = '0;
    case (st)
      3'd0: ucode = C_PCOE | C_MARWA;
      3'd1: ucode = C_RAMOA | C_INWA | C_PCINC;
      3'd2: begin
        if (op == 4'h1 || op == 4'h2) ucode = C_INOA | C_MARWA;
        else if (op == 4'hE)          ucode = C_AOA | C_OUTWA;
        else if (op == 4'hF)          ucode = C_HLT;
      end
      3'd3: begin
        if (op == 4'h1)      ucode = C_RAMOA | C_AWA;
        else if (op == 4'h2) ucode = C_RAMOA | C_BWA;
      end
      3'd4: if (op == 4'h2) ucode = C_SUM | C_AWA | C_FLAGS;
      default: ucode = '0;
    endcase
  endfunction

  task automatic test_reset;
    ctrl = '0; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    clr_n = 1'b0;
    #2;
    tests++; if (instin !== 9'h000) begin fails++; $display("FAIL reset_instin got %h exp 000", instin); end
    tests++; if (out_val !== 8'h00) begin fails++; $display("FAIL reset_out got %h exp 00", out_val); end
    tests++; if (halted !== 1'b0 || bus_err !== 1'b0) begin fails++; $display("FAIL reset_flags got halted=%b bus_err=%b exp 0 0", halted, bus_err); end
    #1 clr_n = 1'b1;
    load_ram(4'h0, 8'h5A);
    act(C_MARWA);
    act(C_RAMOA | C_OUTWA | C_FLAGS);
    act(C_RAMOA | C_INWA);
    tests++; if (instin !== {4'h5, 3'd3, 1'b0, 1'b1}) begin fails++; $display("FAIL pre_reset_instin got %h exp %h", instin, {4'h5, 3'd3, 1'b0, 1'b1}); end
    tests++; if (out_val !== 8'h5A) begin fails++; $display("FAIL pre_reset_out got %h exp 5A", out_val); end
    #2 clr_n = 1'b0;
    #1;
    tests++; if (instin !== 9'h000 || out_val !== 8'h00) begin fails++; $display("FAIL async_reset got instin=%h out=%h exp 000 00", instin, out_val); end
    run = 1'b0;
    #1 clr_n = 1'b1;
    act(C_MARWA);
    act(C_RAMOA | C_OUTWA);
    tests++; if (out_val !== 8'h5A) begin fails++; $display("FAIL ram_retained got %h exp 5A", out_val); end
  endtask

  task automatic test_program;
    logic [8:0] snap;
    int cyc;
    do_reset();
    load_ram(4'h0, 8'h1E); load_ram(4'h1, 8'h2F); load_ram(4'h2, 8'hE0);
    load_ram(4'h3, 8'hF0); load_ram(4'h4, 8'h00);
    load_ram(4'hE, 8'h1C); load_ram(4'hF, 8'h0E);
    cyc = 0;
    while (!halted && cyc < 60) begin
      act(ucode(instin));
      cyc++;
    end
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL prog_halted got %b exp 1 after %0d cycles", halted, cyc); end
    tests++; if (out_val !== 8'h2A) begin fails++; $display("FAIL prog_out got %h exp 2A", out_val); end
    tests++; if (instin[1:0] !== 2'b00) begin fails++; $display("FAIL prog_flags got %b exp 00", instin[1:0]); end
    snap = instin;
    for (int i = 0; i < 5; i++) act(16'($urandom) & ~C_HLT);
    tests++; if (out_val !== 8'h2A || instin !== snap || halted !== 1'b1) begin fails++; $display("FAIL halt_frozen got out=%h instin=%h halted=%b exp 2A %h 1", out_val, instin, halted, snap); end
  endtask

  task automatic test_sub;
    do_reset();
    load_ram(4'h0, 8'h05);
    act(C_MARWA);
    act(C_RAMOA | C_AWA);
    act(C_RAMOA | C_BWA);
    act(C_FLAGS | C_SUB | C_SUM | C_AWA);
    tests++; if (instin[1:0] !== 2'b11) begin fails++; $display("FAIL sub_eq_flags got %b exp 11", instin[1:0]); end
    act(C_AOA | C_OUTWA);
    tests++; if (out_val !== 8'h00) begin fails++; $display("FAIL sub_eq_a got %h exp 00", out_val); end
    load_ram(4'h0, 8'h03);
    act(C_RAMOA | C_AWA);
    act(C_FLAGS | C_SUB | C_SUM | C_AWA);
    tests++; if (instin[1:0] !== 2'b00) begin fails++; $display("FAIL sub_neg_flags got %b exp 00", instin[1:0]); end
    act(C_AOA | C_OUTWA);
    tests++; if (out_val !== 8'hFE) begin fails++; $display("FAIL sub_neg_a got %h exp FE", out_val); end
  endtask

  task automatic test_pc;
    load_ram(4'h0, 8'h0F);
    act(C_MARWA);
    act(C_RAMOA | C_PCJMP);
    act(C_PCOE | C_OUTWA);
    tests++; if (out_val !== 8'h0F) begin fails++; $display("FAIL pc_jump got %h exp 0F", out_val); end
    act(C_PCINC);
    act(C_PCOE | C_OUTWA);
    tests++; if (out_val !== 8'h00) begin fails++; $display("FAIL pc_wrap got %h exp 00", out_val); end
    load_ram(4'h0, 8'h07);
    act(C_RAMOA | C_PCJMP | C_PCINC);
    act(C_PCOE | C_OUTWA);
    tests++; if (out_val !== 8'h07) begin fails++; $display("FAIL pc_jmp_wins got %h exp 07", out_val); end
  endtask

  task automatic test_step;
    run = 1'b0; ctrl = '0;
    tick();
    tests++; if (instin[4:2] !== 3'd0) begin fails++; $display("FAIL step_stopped got %0d exp 0", instin[4:2]); end
    for (int i = 0; i < 7; i++) begin
      act(16'h0000);
      tests++; if (instin[4:2] !== 3'((i + 1) % 5)) begin fails++; $display("FAIL step_seq[%0d] got %0d exp %0d", i, instin[4:2], (i + 1) % 5); end
    end
    run = 1'b0;
    tick();
    tests++; if (instin[4:2] !== 3'd0) begin fails++; $display("FAIL step_drop_run got %0d exp 0", instin[4:2]); end
    run = 1'b1; prog_we = 1'b1; prog_addr = 4'h0; prog_data = 8'h99;
    tick();
    prog_we = 1'b0;
    act(C_MARWA);
    act(C_RAMOA | C_OUTWA);
    tests++; if (out_val !== 8'h07) begin fails++; $display("FAIL prog_we_while_run got %h exp 07", out_val); end
  endtask

  task automatic test_conflict;
    load_ram(4'h0, 8'h11);
    act(C_MARWA);
    act(C_RAMOA | C_AWA);
    act(C_OUTWA);
    tests++; if (out_val !== 8'h00) begin fails++; $display("FAIL conflict_pre_out got %h exp 00", out_val); end
    act(C_AOA | C_PCOE | C_AWA | C_OUTWA);
`ifdef SAP_BUS_CHECK_EN
    tests++; if (bus_err !== 1'b1) begin fails++; $display("FAIL conflict_err got %b exp 1", bus_err); end
    tests++; if (out_val !== 8'h00) begin fails++; $display("FAIL conflict_suppress got %h exp 00", out_val); end
`else
    tests++; if (bus_err !== 1'b0) begin fails++; $display("FAIL conflict_err got %b exp 0", bus_err); end
    tests++; if (out_val !== 8'h11) begin fails++; $display("FAIL conflict_priority got %h exp 11", out_val); end
`endif
    act(C_AOA | C_OUTWA);
    tests++; if (out_val !== 8'h11) begin fails++; $display("FAIL conflict_a got %h exp 11", out_val); end
  endtask

  // Reference model: integers updated from the rules of each strobe, one sample per clock.
  task automatic test_random;
    int mram [16];
    int ma, mb, mpc, mmar, mir, mout, mcf, mzf, mstep;
    int busv, sum, src;
    logic [15:0] c;
    logic [8:0] exp_in;
    logic [15:0] wmask;
    wmask = C_MARWA | C_RAMWA | C_INWA | C_AWA | C_BWA | C_OUTWA |
            C_PCINC | C_PCJMP | C_FLAGS | C_SUB;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      mram[i] = int'($urandom_range(0, 255));
      load_ram(4'(i), 8'(mram[i]));
    end
    ma = 0; mb = 0; mpc = 0; mmar = 0; mir = 0; mout = 0; mcf = 0; mzf = 0; mstep = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        run = 1'b0; ctrl = 16'($urandom);
        prog_we = 1'($urandom); prog_addr = 4'($urandom); prog_data = 8'($urandom);
        if (prog_we) mram[prog_addr] = int'(prog_data);
        mstep = 0;
        tick();
        prog_we = 1'b0;
      end else begin
        src = int'($urandom_range(0, 5));
        c = 16'($urandom) & wmask;
        case (src)
          1: c = c | C_RAMOA;
          2: c = c | C_INOA;
          3: c = c | C_AOA;
          4: c = c | C_SUM;
          5: c = c | C_PCOE;
          default: ;
        endcase
        if ((c & C_SUB) != 0) sum = ma + (255 - mb) + 1;
        else                  sum = ma + mb;
        case (src)
          1: busv = mram[mmar];
          2: busv = mir % 16;
          3: busv = ma;
          4: busv = sum % 256;
          5: busv = mpc;
          default: busv = 0;
        endcase
        if ((c & C_RAMWA) != 0) mram[mmar] = busv;
        if ((c & C_MARWA) != 0) mmar = busv % 16;
        if ((c & C_INWA)  != 0) mir  = busv;
        if ((c & C_AWA)   != 0) ma   = busv;
        if ((c & C_BWA)   != 0) mb   = busv;
        if ((c & C_OUTWA) != 0) mout = busv;
        if ((c & C_FLAGS) != 0) begin
          mcf = (sum > 255) ? 1 : 0;
          mzf = (sum % 256 == 0) ? 1 : 0;
        end
        if ((c & C_PCJMP) != 0)      mpc = busv % 16;
        else if ((c & C_PCINC) != 0) mpc = (mpc + 1) % 16;
        mstep = (mstep + 1) % 5;
        act(c);
      end
      exp_in = 9'((mir / 16) * 32 + mstep * 4 + mcf * 2 + mzf);
      tests++; if (out_val !== 8'(mout)) begin fails++; $display("FAIL rand_out[%0d] got %h exp %h", n, out_val, 8'(mout)); end
      tests++; if (instin !== exp_in) begin fails++; $display("FAIL rand_instin[%0d] got %h exp %h", n, instin, exp_in); end
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_sub();
    test_pc();
    test_step();
    test_conflict();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
